// File: rtl/glm_sbox_layer_ctrl.sv
// Masked PRINCE S-box layer sequencer: feeds 16 two-share nibbles through
// one shared pipelined masked S-box core and reassembles the 64-bit result.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start                  begin a layer (honoured in IDLE or DONE)
//   state_s0/state_s1      64-bit input shares
//   busy, done             FEED/DRAIN indicator, one-cycle result pulse
//   result_s0/result_s1    64-bit output shares
//   rnd_req, rnd_valid     fresh-randomness request / availability
//   rnd, sbox_rnd          fresh word in, forwarded to core on advance
//   sbox_en                core pipeline enable (advance strobe)
//   sbox_in_s0/sbox_in_s1  nibble shares to core
//   sbox_out_s0/_s1        nibble shares from core
module glm_sbox_layer_ctrl #(
    parameter int LAT   = 2,
    parameter int RND_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [63:0]      state_s0,
    input  logic [63:0]      state_s1,
    output logic             busy,
    output logic             done,
    output logic [63:0]      result_s0,
    output logic [63:0]      result_s1,
    output logic             rnd_req,
    input  logic             rnd_valid,
    input  logic [RND_W-1:0] rnd,
    output logic             sbox_en,
    output logic [3:0]       sbox_in_s0,
    output logic [3:0]       sbox_in_s1,
    output logic [RND_W-1:0] sbox_rnd,
    input  logic [3:0]       sbox_out_s0,
    input  logic [3:0]       sbox_out_s1
);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    localparam logic [4:0] LAST_FEED = 5'd15;
    localparam logic [4:0] LAST_ADV  = 5'(15 + LAT);
    localparam logic [4:0] CAP_FIRST = 5'(LAT);

    state_t      state;
    state_t      state_nx;
    logic [4:0]  cnt;
    logic [63:0] lat_s0;
    logic [63:0] lat_s1;
    logic [3:0]  in_s0;
    logic [3:0]  in_s1;
    logic [63:0] res_s0;
    logic [63:0] res_s1;
    logic        adv;
    logic        launch;
    logic [3:0]  nxt_idx;
    logic [3:0]  cap_idx;

    assign busy    = (state == FEED) || (state == DRAIN);
    assign done    = (state == DONE);
    assign adv     = busy & rnd_valid;
    assign launch  = start & ((state == IDLE) || (state == DONE));
    assign rnd_req = busy;
    assign sbox_en = adv;

    assign sbox_rnd   = adv ? rnd : '0;
    assign sbox_in_s0 = in_s0;
    assign sbox_in_s1 = in_s1;
    assign result_s0  = res_s0;
    assign result_s1  = res_s1;

    // Only meaningful under the guards below (cnt < 15, cnt >= LAT),
    // so 4-bit modular arithmetic gives the true nibble index.
    assign nxt_idx = cnt[3:0] + 4'd1;
    assign cap_idx = cnt[3:0] - 4'(LAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = FEED;
            end
            FEED: begin
                if (adv && cnt == LAST_FEED) state_nx = DRAIN;
            end
            DRAIN: begin
                if (adv && cnt == LAST_ADV) state_nx = DONE;
            end
            DONE: begin
                state_nx = start ? FEED : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            lat_s0 <= '0;
            lat_s1 <= '0;
            in_s0  <= '0;
            in_s1  <= '0;
            res_s0 <= '0;
            res_s1 <= '0;
        end else if (launch) begin
            cnt    <= '0;
            lat_s0 <= state_s0;
            lat_s1 <= state_s1;
            // Nibble 0 is presented straight from the input so it is
            // ready on the first FEED cycle.
            in_s0  <= state_s0[3:0];
            in_s1  <= state_s1[3:0];
        end else if (adv) begin
            cnt <= cnt + 5'd1;
            if (cnt < LAST_FEED) begin
                in_s0 <= lat_s0[{nxt_idx, 2'b00} +: 4];
                in_s1 <= lat_s1[{nxt_idx, 2'b00} +: 4];
            end else begin
                in_s0 <= '0;
                in_s1 <= '0;
            end
            if (cnt >= CAP_FIRST) begin
                res_s0[{cap_idx, 2'b00} +: 4] <= sbox_out_s0;
                res_s1[{cap_idx, 2'b00} +: 4] <= sbox_out_s1;
            end
        end
    end

endmodule

// File: tb/tb_glm_sbox_layer_ctrl.sv
// Bench for glm_sbox_layer_ctrl: three builds (LAT=1,2,4), each with a
// behavioural masked PRINCE S-box core, checked against layer-level rules.
module tb_glm_sbox_layer_ctrl;

    localparam logic [3:0] SB [16] = '{
        4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
        4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4
    };

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start [3];
    logic [63:0] s0 [3];
    logic [63:0] s1 [3];
    logic        rv [3];
    logic [3:0]  rnd [3];
    logic        busy [3];
    logic        done [3];
    logic        rreq [3];
    logic        en [3];
    logic [63:0] res0 [3];
    logic [63:0] res1 [3];
    logic [3:0]  in0 [3];
    logic [3:0]  in1 [3];
    logic [3:0]  srnd [3];
    logic [3:0]  out0 [3];
    logic [3:0]  out1 [3];

    logic [3:0]  pf [3][4];
    logic [3:0]  pr [3][4];

    int checks = 0;
    int errors = 0;
    int cur = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        glm_sbox_layer_ctrl #(
            .LAT  ((g == 0) ? 1 : (g == 1) ? 2 : 4),
            .RND_W(4)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[g]),
            .state_s0   (s0[g]),
            .state_s1   (s1[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .result_s0  (res0[g]),
            .result_s1  (res1[g]),
            .rnd_req    (rreq[g]),
            .rnd_valid  (rv[g]),
            .rnd        (rnd[g]),
            .sbox_en    (en[g]),
            .sbox_in_s0 (in0[g]),
            .sbox_in_s1 (in1[g]),
            .sbox_rnd   (srnd[g]),
            .sbox_out_s0(out0[g]),
            .sbox_out_s1(out1[g])
        );
    end

    // Masked core model: unmasked S-box on s0^s1, remasked with the word
    // consumed at issue; LAT enabled stages deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 4; k++) begin
                    pf[i][k] <= '0;
                    pr[i][k] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (en[i]) begin
                    pf[i][0] <= SB[in0[i] ^ in1[i]] ^ srnd[i];
                    pr[i][0] <= srnd[i];
                    for (int k = 1; k < 4; k++) begin
                        pf[i][k] <= pf[i][k-1];
                        pr[i][k] <= pr[i][k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            out0[i] = pf[i][lat_of(i)-1];
            out1[i] = pr[i][lat_of(i)-1];
        end
    end

    function automatic logic [63:0] layer(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) r[4*j +: 4] = SB[x[4*j +: 4]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL LAT=%0d %s got=%h exp=%h", lat_of(cur), tag, got, exp);
        end
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, " busy"}, 64'(busy[i]), 64'd0);
        chk({tag, " done"}, 64'(done[i]), 64'd0);
        chk({tag, " rnd_req"}, 64'(rreq[i]), 64'd0);
        chk({tag, " sbox_en"}, 64'(en[i]), 64'd0);
        chk({tag, " in0"}, 64'(in0[i]), 64'd0);
        chk({tag, " in1"}, 64'(in1[i]), 64'd0);
        chk({tag, " sbox_rnd"}, 64'(srnd[i]), 64'd0);
        chk({tag, " res0"}, res0[i], 64'd0);
        chk({tag, " res1"}, res1[i], 64'd0);
    endtask

    task automatic launch(input int i, input logic [63:0] a0,
                          input logic [63:0] a1);
        start[i] = 1'b1;
        s0[i]    = a0;
        s1[i]    = a1;
    endtask

    // Follows one run whose start edge is the next rising edge.
    task automatic run(input int i, input logic [63:0] a0,
                       input logic [63:0] a1, input int stall_at,
                       input int stall_len, input int poke_at,
                       input int abort_at, input bit chain,
                       input logic [63:0] b0, input logic [63:0] b1);
        int k = 0;
        int nadv = 0;
        int nbusy = 0;
        int stalled = 0;
        int total;
        int lat;
        bit fin = 0;
        logic [3:0] e0;
        logic [3:0] e1;
        cur   = i;
        lat   = lat_of(i);
        total = 16 + lat;
        @(negedge clk);
        start[i] = 1'b0;
        while (!fin) begin
            rv[i] = !(nadv == stall_at && stalled < stall_len);
            if (!rv[i]) stalled++;
            rnd[i] = 4'($urandom);
            if (k == poke_at) begin
                start[i] = 1'b1;
                s0[i]    = {$urandom, $urandom};
                s1[i]    = {$urandom, $urandom};
            end else if (k == poke_at + 1) begin
                start[i] = 1'b0;
            end
            #1;
            if (nadv == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_zero(i, "abort");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done[i]) begin
                chk("done latency", 64'(k), 64'(total + stalled));
                chk("advances", 64'(nadv), 64'(total));
                chk("busy cycles", 64'(nbusy), 64'(total + stalled));
                chk("result", res0[i] ^ res1[i], layer(a0 ^ a1));
                chk("done busy", 64'(busy[i]), 64'd0);
                chk("done rnd_req", 64'(rreq[i]), 64'd0);
                chk("done in0", 64'(in0[i]), 64'd0);
                fin = 1;
                if (chain) launch(i, b0, b1);
            end else begin
                if (busy[i]) begin
                    nbusy++;
                    e0 = (nadv < 16) ? a0[4*nadv +: 4] : 4'h0;
                    e1 = (nadv < 16) ? a1[4*nadv +: 4] : 4'h0;
                    chk("sbox_in_s0", 64'(in0[i]), 64'(e0));
                    chk("sbox_in_s1", 64'(in1[i]), 64'(e1));
                    chk("sbox_en", 64'(en[i]), 64'(rv[i]));
                    chk("sbox_rnd", 64'(srnd[i]), rv[i] ? 64'(rnd[i]) : 64'd0);
                    chk("rnd_req", 64'(rreq[i]), 64'd1);
                end
                if (en[i]) nadv++;
                if (k >= 200) begin
                    chk("timeout", 64'(k), 64'(total + stalled));
                    fin = 1;
                end
                @(negedge clk);
                k++;
            end
        end
        if (!chain) begin
            for (int n = 0; n < 3; n++) begin
                @(negedge clk);
                #1;
                chk("no extra done", 64'(done[i]), 64'd0);
            end
        end
    endtask

    initial begin
        logic [63:0] a;
        for (int i = 0; i < 3; i++) begin
            start[i] = 0;
            s0[i]    = '0;
            s1[i]    = '0;
            rv[i]    = 0;
            rnd[i]   = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cur = i;
            chk_zero(i, "reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            launch(i, 64'h0123456789ABCDEF, 64'h0);
            run(i, 64'h0123456789ABCDEF, 64'h0, -1, 0, -1, -1, 0, 0, 0);
            launch(i, 64'h0123456789ABCDEF, 64'h0);
            run(i, 64'h0123456789ABCDEF, 64'h0, 7, 5, -1, -1, 0, 0, 0);
            a = {$urandom, $urandom};
            launch(i, a, 64'h0);
            run(i, a, 64'h0, -1, 0, 6, -1, 0, 0, 0);
            a = {$urandom, $urandom};
            launch(i, a, {$urandom, $urandom});
            run(i, a, s1[i], -1, 0, -1, 10, 0, 0, 0);
            a = {$urandom, $urandom};
            launch(i, a, {$urandom, $urandom});
            run(i, a, s1[i], -1, 0, -1, -1, 1,
                64'hFFFF0000FFFF0000, 64'h1111111111111111);
            run(i, 64'hFFFF0000FFFF0000, 64'h1111111111111111,
                -1, 0, -1, -1, 0, 0, 0);
            for (int r = 0; r < 3; r++) begin
                a = {$urandom, $urandom};
                launch(i, a, {$urandom, $urandom});
                run(i, a, s1[i], int'($urandom_range(0, 15 + lat_of(i))),
                    int'($urandom_range(1, 6)), -1, -1, 0, 0, 0);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
